// File: rtl/counter_updown_mod.sv
// ---------------------------------------------------------------------------
// counter_updown_mod
//   Parametrised up/down modulo counter with synchronous parallel load,
//   programmable terminal value TOP, wrap (SAT=0) or saturate (SAT=1)
//   behaviour at the boundaries, and a registered terminal-count pulse.
//
//   Optional feature macro: CNT_PRESCALE_EN
//     When defined, an internal prescaler divides the enable so the counter
//     steps only on every PRE-th enabled cycle. When undefined, every
//     enabled cycle is a step and PRE is only range-checked.
// ---------------------------------------------------------------------------
module counter_updown_mod #(
   parameter int unsigned dw   = 8,
   parameter int unsigned TOP  = 7,
   parameter int unsigned INIT = 7,
   parameter int unsigned SAT  = 0,
   parameter int unsigned PRE  = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ena,
   input  logic          up,
   input  logic          load,
   input  logic [dw-1:0] load_val,
   output logic [dw-1:0] result,
   output logic          tc
);

   localparam logic [dw-1:0] TOP_V  = dw'(TOP);
   localparam logic [dw-1:0] INIT_V = dw'(INIT);
   localparam logic          SAT_V  = (SAT != 0);

   // Elaboration-time parameter sanity checks
   if (INIT > TOP) begin : g_bad_init
      $error("counter_updown_mod: INIT must not exceed TOP");
   end
   if ((TOP >> dw) != 0) begin : g_bad_top
      $error("counter_updown_mod: TOP must fit in dw bits");
   end
   if (PRE < 1) begin : g_bad_pre
      $error("counter_updown_mod: PRE must be at least 1");
   end

   logic          step_c;
   logic [dw-1:0] result_nxt;
   logic          tc_nxt;

`ifdef CNT_PRESCALE_EN
   localparam int unsigned   PW       = (PRE > 1) ? $clog2(PRE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);

   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_nxt;

   // Prescaler next value: cleared by load, advances and wraps on ena
   always_comb begin
      pre_nxt = pre_q;
      if (load) begin
         pre_nxt = '0;
      end else if (ena) begin
         pre_nxt = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
      end
   end

   // Prescaler register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_nxt;
      end
   end

   // A counter step happens only on the last prescaler phase
   always_comb begin
      step_c = ena && !load && (pre_q == PRE_LAST);
   end
`else
   // Every enabled, non-load cycle is a counter step
   always_comb begin
      step_c = ena && !load;
   end
`endif

   // Next count and terminal-count: load > step > hold
   always_comb begin
      result_nxt = result;
      tc_nxt     = 1'b0;
      if (load) begin
         result_nxt = (load_val > TOP_V) ? TOP_V : load_val;
      end else if (step_c) begin
         if (up) begin
            if (result == TOP_V) begin
               tc_nxt     = 1'b1;
               result_nxt = SAT_V ? TOP_V : '0;
            end else begin
               result_nxt = result + dw'(1);
            end
         end else begin
            if (result == '0) begin
               tc_nxt     = 1'b1;
               result_nxt = SAT_V ? '0 : TOP_V;
            end else begin
               result_nxt = result - dw'(1);
            end
         end
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result <= INIT_V;
         tc     <= 1'b0;
      end else begin
         result <= result_nxt;
         tc     <= tc_nxt;
      end
   end

endmodule

// File: tb/tb_counter_updown_mod.sv
// ---------------------------------------------------------------------------
// tb_counter_updown_mod
//   Two instances driven by the same inputs: a wrapping counter with the
//   default parameters and a saturating counter with TOP=10, INIT=3.
//   A stimulus process pushes expected outputs into a scoreboard queue; a
//   monitor pops one entry after every posedge and compares.
//   Honors CNT_PRESCALE_EN in the reference model when defined.
// ---------------------------------------------------------------------------
module tb_counter_updown_mod;

   localparam int unsigned DW  = 8;
   localparam int unsigned PRE = 4;

   localparam int TOPS  [2] = '{7, 10};
   localparam int INITS [2] = '{7, 3};
   localparam int SATS  [2] = '{0, 1};

   typedef struct {
      int r0;
      int t0;
      int r1;
      int t1;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          ena;
   logic          up;
   logic          load;
   logic [DW-1:0] load_val;
   logic [DW-1:0] result0;
   logic          tc0;
   logic [DW-1:0] result1;
   logic          tc1;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state
   int m_cnt [2];
   int m_pre [2];
   int m_tc  [2];

   counter_updown_mod #(.dw(DW), .TOP(7), .INIT(7), .SAT(0), .PRE(PRE)) dut (
      .clk(clk), .reset(reset), .ena(ena), .up(up), .load(load),
      .load_val(load_val), .result(result0), .tc(tc0)
   );

   counter_updown_mod #(.dw(DW), .TOP(10), .INIT(3), .SAT(1), .PRE(PRE)) dut_sat (
      .clk(clk), .reset(reset), .ena(ena), .up(up), .load(load),
      .load_val(load_val), .result(result1), .tc(tc1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = INITS[i];
         m_pre[i] = 0;
         m_tc[i]  = 0;
      end
   endtask

   // Behavioural next-state computed from the counting rules with integers
   task automatic model_step(input int e, input int u, input int ld, input int lv);
      int hit;
      int md;
      for (int i = 0; i < 2; i++) begin
         md = TOPS[i] + 1;
         if (ld != 0) begin
            m_cnt[i] = (lv > TOPS[i]) ? TOPS[i] : lv;
            m_tc[i]  = 0;
            m_pre[i] = 0;
         end else if (e != 0) begin
            hit = 1;
`ifdef CNT_PRESCALE_EN
            hit      = (m_pre[i] == PRE - 1) ? 1 : 0;
            m_pre[i] = (hit != 0) ? 0 : m_pre[i] + 1;
`endif
            m_tc[i] = 0;
            if (hit != 0) begin
               if (u != 0) begin
                  m_tc[i] = (m_cnt[i] == TOPS[i]) ? 1 : 0;
                  if (!(m_tc[i] != 0 && SATS[i] != 0)) m_cnt[i] = (m_cnt[i] + 1) % md;
               end else begin
                  m_tc[i] = (m_cnt[i] == 0) ? 1 : 0;
                  if (!(m_tc[i] != 0 && SATS[i] != 0)) m_cnt[i] = (m_cnt[i] + TOPS[i]) % md;
               end
            end
         end else begin
            m_tc[i] = 0;
         end
      end
   endtask

   // Drive one cycle of inputs and queue the expected post-edge outputs
   task automatic drive(input int e, input int u, input int ld, input int lv);
      exp_t x;
      @(negedge clk);
      ena      = e[0];
      up       = u[0];
      load     = ld[0];
      load_val = DW'(lv);
      model_step(e, u, ld, lv);
      x.r0 = m_cnt[0];
      x.t0 = m_tc[0];
      x.r1 = m_cnt[1];
      x.t1 = m_tc[1];
      sb.push_back(x);
   endtask

   // Monitor: compare DUT outputs against the oldest expectation
   always begin
      exp_t x;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         chk("result0", int'(result0), x.r0);
         chk("tc0",     int'(tc0),     x.t0);
         chk("result1", int'(result1), x.r1);
         chk("tc1",     int'(tc1),     x.t1);
      end
   end

   task automatic drain();
      int budget;
      budget = 20;
      while (sb.size() > 0 && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      if (sb.size() > 0) begin
         $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
         n_checks++;
         sb.delete();
      end
   endtask

   // Asynchronous reset between edges, checked before the next posedge
   task automatic async_reset_check();
      drain();
      @(negedge clk);
      ena  = 1'b0;
      load = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("rst_result0", int'(result0), INITS[0]);
      chk("rst_tc0",     int'(tc0),     0);
      chk("rst_result1", int'(result1), INITS[1]);
      chk("rst_tc1",     int'(tc1),     0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      ena      = 1'b0;
      up       = 1'b0;
      load     = 1'b0;
      load_val = '0;
      model_reset();
      #23;
      chk("init_result0", int'(result0), 7);
      chk("init_tc0",     int'(tc0),     0);
      @(negedge clk);
      reset = 1'b0;

      // Count down through zero: wrap to TOP with a tc pulse
      for (int k = 0; k < 10; k++) drive(1, 0, 0, 0);
      // Count up through TOP (both instances) and into saturation on dut_sat
      drive(0, 0, 1, 7);
      for (int k = 0; k < 14; k++) drive(1, 1, 0, 0);
      // Load takes priority over ena; clamping of out-of-range values
      drive(1, 1, 1, 3);
      drive(1, 1, 1, 200);
      drive(1, 0, 1, 255);
      // Hold at 4 for five cycles
      drive(0, 0, 1, 4);
      for (int k = 0; k < 5; k++) drive(0, $urandom_range(0, 1), 0, 0);
      // Saturate at zero going down
      drive(0, 0, 1, 0);
      for (int k = 0; k < 3; k++) drive(1, 0, 0, 0);
      // Load mid-count restarts any prescaling
      for (int k = 0; k < 3; k++) drive(1, 0, 0, 0);
      drive(1, 0, 1, 6);
      for (int k = 0; k < 6; k++) drive(1, 0, 0, 0);

      async_reset_check();

      // Randomised traffic biased toward long enabled runs
      for (int k = 0; k < 400; k++) begin
         int lv;
         lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                           : int'($urandom_range(0, 12));
         drive(($urandom_range(0, 7) != 0) ? 1 : 0,
               ($urandom_range(0, 15) < 9) ? 1 : 0,
               ($urandom_range(0, 19) == 0) ? 1 : 0,
               lv);
         if (k == 200) async_reset_check();
      end

      drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
